// File: rtl/pio_pkg.sv
// Shared constants and types for the PIO host command decoder.
package pio_pkg;

  localparam int INSTR_W    = 16;
  localparam int IMEM_DEPTH = 32;

  localparam logic [5:0] ACT_NOP       = 6'd0;
  localparam logic [5:0] ACT_INSTR     = 6'd1;
  localparam logic [5:0] ACT_EN        = 6'd2;
  localparam logic [5:0] ACT_CLKDIV    = 6'd3;
  localparam logic [5:0] ACT_PINCTRL   = 6'd4;
  localparam logic [5:0] ACT_EXECCTRL  = 6'd5;
  localparam logic [5:0] ACT_SHIFTCTRL = 6'd6;
  localparam logic [5:0] ACT_TX_PUSH   = 6'd7;
  localparam logic [5:0] ACT_RX_POP    = 6'd8;
  localparam logic [5:0] ACT_RESTART   = 6'd9;

  localparam logic [31:0] CLKDIV_RST    = 32'h0001_0000;
  localparam logic [31:0] EXECCTRL_RST  = 32'h0001_F000;
  localparam logic [31:0] SHIFTCTRL_RST = 32'h000C_0000;
  localparam logic [31:0] PINCTRL_RST   = 32'h1400_0000;

  typedef struct packed {
    logic [31:0] clkdiv;
    logic [31:0] execctrl;
    logic [31:0] shiftctrl;
    logic [31:0] pinctrl;
  } sm_cfg_t;

  localparam sm_cfg_t SM_CFG_RST = '{
    clkdiv:    CLKDIV_RST,
    execctrl:  EXECCTRL_RST,
    shiftctrl: SHIFTCTRL_RST,
    pinctrl:   PINCTRL_RST
  };

endpackage

// File: rtl/pio_fifo.sv
// Synchronous FIFO with registered occupancy count; a pop on a full FIFO
// frees the slot for a push in the same cycle.
module pio_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pio_host_if.sv
// Host command decoder: one command per clock into instruction memory,
// per-machine configuration, enable/restart control and TX/RX FIFOs.
module pio_host_if
  import pio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SM     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            action,
  input  logic [1:0]            mindex,
  input  logic [4:0]            index,
  input  logic [31:0]           din,
  output logic [31:0]           dout,
  input  logic [5*NUM_SM-1:0]   pc,
  output logic [16*NUM_SM-1:0]  instr,
  output logic [32*NUM_SM-1:0]  clkdiv,
  output logic [32*NUM_SM-1:0]  execctrl,
  output logic [32*NUM_SM-1:0]  shiftctrl,
  output logic [32*NUM_SM-1:0]  pinctrl,
  output logic [NUM_SM-1:0]     en,
  output logic [NUM_SM-1:0]     restart,
  input  logic [NUM_SM-1:0]     tx_pull,
  output logic [32*NUM_SM-1:0]  tx_data,
  output logic [NUM_SM-1:0]     tx_full,
  output logic [NUM_SM-1:0]     tx_empty,
  input  logic [NUM_SM-1:0]     rx_push,
  input  logic [32*NUM_SM-1:0]  rx_wdata,
  output logic [NUM_SM-1:0]     rx_full,
  output logic [NUM_SM-1:0]     rx_empty
);

  logic [INSTR_W-1:0] instr_mem_q [IMEM_DEPTH];
  logic [INSTR_W-1:0] instr_mem_d [IMEM_DEPTH];
  sm_cfg_t            cfg_q [NUM_SM];
  sm_cfg_t            cfg_d [NUM_SM];
  logic [NUM_SM-1:0]  en_q, en_d;
  logic [NUM_SM-1:0]  restart_q, restart_d;
  logic [31:0]        dout_q, dout_d;

  logic [NUM_SM-1:0]  tx_push;
  logic [NUM_SM-1:0]  rx_pop;
  logic [31:0]        rx_rdata [NUM_SM];

  always_comb begin
    instr_mem_d = instr_mem_q;
    cfg_d       = cfg_q;
    en_d        = en_q;
    restart_d   = '0;
    dout_d      = dout_q;
    case (action)
      ACT_INSTR:     instr_mem_d[index]       = din[INSTR_W-1:0];
      ACT_EN:        en_d                     = din[NUM_SM-1:0];
      ACT_CLKDIV:    cfg_d[mindex].clkdiv     = din;
      ACT_PINCTRL:   cfg_d[mindex].pinctrl    = din;
      ACT_EXECCTRL:  cfg_d[mindex].execctrl   = din;
      ACT_SHIFTCTRL: cfg_d[mindex].shiftctrl  = din;
      ACT_RX_POP:    if (!rx_empty[mindex]) dout_d = rx_rdata[mindex];
      ACT_RESTART:   restart_d                = din[NUM_SM-1:0];
      default:       ;
    endcase
  end

  // Reset wins over any command presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < IMEM_DEPTH; i++) instr_mem_q[i] <= '0;
      for (int k = 0; k < NUM_SM; k++)     cfg_q[k]       <= SM_CFG_RST;
      en_q      <= '0;
      restart_q <= '0;
      dout_q    <= '0;
    end else begin
      instr_mem_q <= instr_mem_d;
      cfg_q       <= cfg_d;
      en_q        <= en_d;
      restart_q   <= restart_d;
      dout_q      <= dout_d;
    end
  end

  assign en      = en_q;
  assign restart = restart_q;
  assign dout    = dout_q;

  for (genvar k = 0; k < NUM_SM; k++) begin : g_sm
    assign tx_push[k] = (action == ACT_TX_PUSH) && (mindex == 2'(k));
    assign rx_pop[k]  = (action == ACT_RX_POP)  && (mindex == 2'(k));

    pio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tx (
      .clk   (clk),
      .reset (reset),
      .push  (tx_push[k]),
      .wdata (din),
      .pop   (tx_pull[k]),
      .rdata (tx_data[32*k +: 32]),
      .full  (tx_full[k]),
      .empty (tx_empty[k])
    );

    pio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_rx (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push[k]),
      .wdata (rx_wdata[32*k +: 32]),
      .pop   (rx_pop[k]),
      .rdata (rx_rdata[k]),
      .full  (rx_full[k]),
      .empty (rx_empty[k])
    );

    assign instr[16*k +: 16]     = instr_mem_q[pc[5*k +: 5]];
    assign clkdiv[32*k +: 32]    = cfg_q[k].clkdiv;
    assign execctrl[32*k +: 32]  = cfg_q[k].execctrl;
    assign shiftctrl[32*k +: 32] = cfg_q[k].shiftctrl;
    assign pinctrl[32*k +: 32]   = cfg_q[k].pinctrl;
  end

endmodule

// File: tb/tb_pio_host_if.sv
// Self-checking bench for pio_host_if: directed plan steps followed by random
// commands, all compared against a queue-based reference model.
module tb_pio_host_if;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   action;
  logic [1:0]   mindex;
  logic [4:0]   index;
  logic [31:0]  din;
  logic [31:0]  dout;
  logic [19:0]  pc;
  logic [63:0]  instr;
  logic [127:0] clkdiv, execctrl, shiftctrl, pinctrl;
  logic [3:0]   en, restart;
  logic [3:0]   tx_pull;
  logic [127:0] tx_data;
  logic [3:0]   tx_full, tx_empty;
  logic [3:0]   rx_push;
  logic [127:0] rx_wdata;
  logic [3:0]   rx_full, rx_empty;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] instr_m [32];
  logic [31:0] clkdiv_m [4], execctrl_m [4], shiftctrl_m [4], pinctrl_m [4];
  logic [3:0]  en_m, restart_m;
  logic [31:0] dout_m;
  logic [31:0] tx_q [4][$];
  logic [31:0] rx_q [4][$];

  always #5 clk = ~clk;

  pio_host_if #(.FIFO_DEPTH(DEPTH), .NUM_SM(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .action    (action),
    .mindex    (mindex),
    .index     (index),
    .din       (din),
    .dout      (dout),
    .pc        (pc),
    .instr     (instr),
    .clkdiv    (clkdiv),
    .execctrl  (execctrl),
    .shiftctrl (shiftctrl),
    .pinctrl   (pinctrl),
    .en        (en),
    .restart   (restart),
    .tx_pull   (tx_pull),
    .tx_data   (tx_data),
    .tx_full   (tx_full),
    .tx_empty  (tx_empty),
    .rx_push   (rx_push),
    .rx_wdata  (rx_wdata),
    .rx_full   (rx_full),
    .rx_empty  (rx_empty)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic [31:0] w;
    if (reset) begin
      for (int i = 0; i < 32; i++) instr_m[i] = 16'h0;
      for (int k = 0; k < 4; k++) begin
        clkdiv_m[k]    = 32'h0001_0000;
        execctrl_m[k]  = 32'h0001_F000;
        shiftctrl_m[k] = 32'h000C_0000;
        pinctrl_m[k]   = 32'h1400_0000;
        tx_q[k].delete();
        rx_q[k].delete();
      end
      en_m = 4'h0; restart_m = 4'h0; dout_m = 32'h0;
    end else begin
      restart_m = (action == 6'd9) ? din[3:0] : 4'h0;
      case (action)
        6'd1: instr_m[index]      = din[15:0];
        6'd2: en_m                = din[3:0];
        6'd3: clkdiv_m[mindex]    = din;
        6'd4: pinctrl_m[mindex]   = din;
        6'd5: execctrl_m[mindex]  = din;
        6'd6: shiftctrl_m[mindex] = din;
        default: ;
      endcase
      // Pop is taken before push, so a full FIFO accepts a push alongside a pop.
      for (int k = 0; k < 4; k++) begin
        if (tx_pull[k] && tx_q[k].size() > 0) w = tx_q[k].pop_front();
        if (action == 6'd7 && mindex == k && tx_q[k].size() < DEPTH) tx_q[k].push_back(din);
        if (action == 6'd8 && mindex == k && rx_q[k].size() > 0) dout_m = rx_q[k].pop_front();
        if (rx_push[k] && rx_q[k].size() < DEPTH) rx_q[k].push_back(rx_wdata[32*k +: 32]);
      end
    end
  endtask

  task automatic check_all();
    check("dout", dout, dout_m);
    check("en", en, en_m);
    check("restart", restart, restart_m);
    for (int k = 0; k < 4; k++) begin
      check("clkdiv", clkdiv[32*k +: 32], clkdiv_m[k]);
      check("execctrl", execctrl[32*k +: 32], execctrl_m[k]);
      check("shiftctrl", shiftctrl[32*k +: 32], shiftctrl_m[k]);
      check("pinctrl", pinctrl[32*k +: 32], pinctrl_m[k]);
      check("tx_full", tx_full[k], tx_q[k].size() == DEPTH);
      check("tx_empty", tx_empty[k], tx_q[k].size() == 0);
      check("rx_full", rx_full[k], rx_q[k].size() == DEPTH);
      check("rx_empty", rx_empty[k], rx_q[k].size() == 0);
      if (tx_q[k].size() > 0) check("tx_data", tx_data[32*k +: 32], tx_q[k][0]);
    end
    pc = $urandom;
    #1;
    for (int k = 0; k < 4; k++) check("instr", instr[16*k +: 16], instr_m[pc[5*k +: 5]]);
  endtask

  task automatic cycle(input logic rst, input logic [5:0] act, input logic [1:0] mi,
                       input logic [4:0] idx, input logic [31:0] d, input logic [3:0] pull,
                       input logic [3:0] push, input logic [127:0] wd);
    reset = rst; action = act; mindex = mi; index = idx; din = d;
    tx_pull = pull; rx_push = push; rx_wdata = wd;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic cmd(input logic [5:0] act, input logic [1:0] mi, input logic [4:0] idx,
                     input logic [31:0] d);
    cycle(1'b0, act, mi, idx, d, 4'h0, 4'h0, 128'h0);
  endtask

  initial begin
    reset = 1'b1; action = '0; mindex = '0; index = '0; din = '0;
    pc = '0; tx_pull = '0; rx_push = '0; rx_wdata = '0;

    // Reset state
    cycle(1'b1, 6'd0, 2'd0, 5'd0, 32'h0, 4'h0, 4'h0, 128'h0);
    cycle(1'b1, 6'd0, 2'd0, 5'd0, 32'h0, 4'h0, 4'h0, 128'h0);
    check("rst_clkdiv", clkdiv, {4{32'h0001_0000}});
    check("rst_execctrl", execctrl, {4{32'h0001_F000}});
    check("rst_shiftctrl", shiftctrl, {4{32'h000C_0000}});
    check("rst_pinctrl", pinctrl, {4{32'h1400_0000}});
    check("rst_fifo_empty", {tx_empty, rx_empty}, 8'hFF);

    // Instruction memory fill
    for (int i = 0; i < 32; i++) cmd(6'd1, 2'd0, 5'(i), 32'hE000 + i);
    pc = {4{5'd31}};
    #1;
    check("instr_pc31", instr, {4{16'hE01F}});
    pc = {5'd3, 5'd17, 5'd0, 5'd9};
    #1;
    check("instr_mixed", instr, {16'hE003, 16'hE011, 16'hE000, 16'hE009});

    // Per-machine clkdiv
    cmd(6'd3, 2'd2, 5'd0, 32'h0002_8000);
    check("clkdiv_sm2", clkdiv, {32'h0001_0000, 32'h0002_8000, 32'h0001_0000, 32'h0001_0000});

    // TX overflow and drain
    for (int i = 1; i <= 5; i++) begin
      cmd(6'd7, 2'd1, 5'd0, 32'(i));
      if (i == 4) check("tx_full1_after4", tx_full[1], 1'b1);
    end
    for (int j = 0; j < 4; j++) begin
      check("tx1_head", tx_data[63:32], 32'(j + 1));
      cycle(1'b0, 6'd0, 2'd0, 5'd0, 32'h0, 4'b0010, 4'h0, 128'h0);
    end
    check("tx_empty1", tx_empty[1], 1'b1);

    // RX pop and pop-on-empty
    cycle(1'b0, 6'd0, 2'd0, 5'd0, 32'h0, 4'h0, 4'b0001, {96'h0, 32'hDEAD_BEEF});
    cmd(6'd8, 2'd0, 5'd0, 32'h0);
    check("dout_deadbeef", dout, 32'hDEAD_BEEF);
    cmd(6'd8, 2'd0, 5'd0, 32'h0);
    check("dout_hold", dout, 32'hDEAD_BEEF);
    check("rx_empty0", rx_empty[0], 1'b1);

    // Push and pop together on a full RX3
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 6'd0, 2'd0, 5'd0, 32'h0, 4'h0, 4'b1000, {32'hA000_0000 + i, 96'h0});
    check("rx_full3", rx_full[3], 1'b1);
    cycle(1'b0, 6'd8, 2'd3, 5'd0, 32'h0, 4'h0, 4'b1000, {32'hA000_0004, 96'h0});
    check("rx3_both_dout", dout, 32'hA000_0000);
    check("rx3_still_full", rx_full[3], 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cmd(6'd8, 2'd3, 5'd0, 32'h0);
      check("rx3_drain", dout, 32'hA000_0000 + i);
    end

    // Enable, restart pulse, then reset during a push
    cmd(6'd2, 2'd0, 5'd0, 32'hF);
    check("en_f", en, 4'hF);
    cmd(6'd9, 2'd0, 5'd0, 32'h5);
    check("restart_5", restart, 4'h5);
    cmd(6'd0, 2'd0, 5'd0, 32'h0);
    check("restart_clear", restart, 4'h0);
    cmd(6'd7, 2'd0, 5'd0, 32'h1234);
    cycle(1'b1, 6'd7, 2'd0, 5'd0, 32'h5678, 4'h0, 4'hF, {4{32'h1}});
    check("reset_en", en, 4'h0);
    check("reset_empty", {tx_empty, rx_empty}, 8'hFF);
    check("reset_clkdiv", clkdiv, {4{32'h0001_0000}});
    pc = {4{5'd31}};
    #1;
    check("reset_instr", instr, 64'h0);

    // Random commands against the model
    for (int n = 0; n < 600; n++) begin
      logic [5:0] act;
      int r;
      r = $urandom_range(0, 15);
      if (r <= 9)       act = 6'(r);
      else if (r <= 11) act = 6'($urandom_range(10, 63));
      else              act = 6'd7;
      cycle(($urandom_range(0, 79) == 0), act, 2'($urandom), 5'($urandom), $urandom,
            4'($urandom) & 4'($urandom), 4'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_host_if.md
# pio_host_if

Host-side command decoder for the PIO block. It is the receiving end of the `action`/`din`/`index`/`mindex` command bus that top-level loaders drive. It decodes one command per clock into instruction-memory writes, per-machine configuration registers, machine enable/restart control, and per-machine TX/RX FIFOs. The state machines read instructions, configuration and TX data from it, and return RX data to it.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entries per TX and per RX FIFO; must be a power of 2.
- `NUM_SM`, 4: number of state machines; fixed at 4 because `mindex` is 2 bits.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `action` in 6: command code; 0 = NOP.
- `mindex` in 2: target machine.
- `index` in 5: instruction address.
- `din` in 32: command data.
- `dout` out 32: RX pull result, registered.
- `pc` in 20: four 5-bit read addresses; bits [5k+4:5k] belong to SM k.
- `instr` out 64: four 16-bit instructions; bits [16k+15:16k] belong to SM k; combinational read.
- `clkdiv`, `execctrl`, `shiftctrl`, `pinctrl` out 128 each: four packed 32-bit registers each.
- `en` out 4: machine enable.
- `restart` out 4: one-cycle restart pulses.
- `tx_pull` in 4: SM pops its TX FIFO.
- `tx_data` out 128: TX FIFO heads.
- `tx_full` out 4: TX FIFO full flags.
- `tx_empty` out 4: TX FIFO empty flags.
- `rx_push` in 4: SM pushes its RX FIFO.
- `rx_wdata` in 128: RX data from each SM.
- `rx_full` out 4: RX FIFO full flags.
- `rx_empty` out 4: RX FIFO empty flags.

## Operation
- `action` is sampled every cycle, and each cycle carrying a non-zero code executes exactly once. A host that holds a code for N cycles gets N executions.
- Command codes:
  - 1 = `instr_mem[index] <= din[15:0]`.
  - 2 = `en <= din[3:0]`.
  - 3 = `clkdiv[mindex] <= din`.
  - 4 = `pinctrl[mindex] <= din`.
  - 5 = `execctrl[mindex] <= din`.
  - 6 = `shiftctrl[mindex] <= din`.
  - 7 = push `din` into `TX[mindex]`.
  - 8 = pop `RX[mindex]` into `dout`.
  - 9 = `restart <= din[3:0]` for one cycle.
  - 10–63 = ignored; no state change.
- Reset values:
  - `instr_mem` is all 0.
  - `en` = 0, `restart` = 0, `dout` = 0.
  - `clkdiv` = 0x0001_0000.
  - `execctrl` = 0x0001_F000 (wrap_top = 31).
  - `shiftctrl` = 0x000C_0000.
  - `pinctrl` = 0x1400_0000.
  - All FIFOs are empty.
- Reset asserted mid-sequence takes precedence over any command in the same cycle.
- FIFOs: one `pio_fifo` instance per direction per machine, each with its own read and write pointers plus a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push to a full FIFO is dropped; contents and `dout` are unchanged.
- Pop from an empty RX FIFO leaves `dout` unchanged.
- A `tx_pull` on an empty TX FIFO is ignored.
- Simultaneous push and pop on the same FIFO:
  - If not empty, both happen and the count is unchanged.
  - If empty, only the push happens.
  - If full, both happen. The pop is processed first, so the push is accepted.
- `restart` clears itself the cycle after it is issued. A code-9 command on consecutive cycles gives consecutive pulses.

## Timing
- Register, memory and FIFO writes are visible on outputs the cycle after the command.
- `instr` reflects `pc` combinationally and shows a write to the same address from the next cycle on.
- `dout` updates one cycle after code 8.
- `tx_data` shows the FIFO head combinationally. After a `tx_pull`, the next entry appears on the following cycle.
- `tx_full`, `tx_empty`, `rx_full` and `rx_empty` are registered-count decodes that update one cycle after the causing event.

## Structure
- `pio_pkg` holds:
  - Action code localparams: `ACT_NOP` … `ACT_RESTART`.
  - Reset-value constants for the four configuration registers.
  - The instruction width, 16.
- Sub-module `pio_fifo`: synchronous, parameterised depth and width, with full and empty flags. It is instantiated 8 times.

## Test plan
- Reset, then hold action=1 for 32 cycles with index 0..31 and din=0xE000+i -> `instr` at pc=i reads 0xE000+i, and pc=31 reads 0xE01F.
- Action=3, mindex=2, din=0x0002_8000 -> clkdiv[95:64] = 0x0002_8000; the other machines keep 0x0001_0000.
- Five pushes (code 7, mindex=1, din=1..5) -> `tx_full[1]`=1 after the 4th push, and the 5th is dropped. Four `tx_pull[1]` pops then yield 1, 2, 3, 4, after which `tx_empty[1]`=1.
- `rx_push[0]` with 0xDEAD_BEEF, then code 8 with mindex=0 -> `dout`=0xDEAD_BEEF one cycle later. A second code 8 leaves `dout` unchanged and `rx_empty[0]`=1.
- Simultaneous `rx_push[3]` and code 8 on a full RX3 -> the count stays 4, `dout` = the oldest entry, and the pushed word becomes the tail.
- Code 2 with din=0xF, then code 9 with din=0x5, then `reset` mid-push -> en=0xF, then restart=0x5 for exactly one cycle, then reset restores all defaults.
